// File: rtl/axi_lite_pkg.sv
// Shared types for the two-requester AXI4-Lite arbiter: response codes, owner and FSM state.
package axi_lite_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic {
    OwnIf,
    OwnDm
  } owner_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdAr,
    StRdR,
    StWrAww,
    StWrB,
    StRsp
  } state_e;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite master-side channel bundle; master modport faces the arbiter, slave the memory side.
interface axi_lite_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0]   axi_awaddr;
  logic                axi_awvalid;
  logic [2:0]          axi_awprot;
  logic                axi_awready;
  logic [DATA_W-1:0]   axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic                axi_wvalid;
  logic                axi_wready;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid;
  logic                axi_bready;
  logic [ADDR_W-1:0]   axi_araddr;
  logic                axi_arvalid;
  logic [2:0]          axi_arprot;
  logic                axi_arready;
  logic [DATA_W-1:0]   axi_rdata;
  logic [1:0]          axi_rresp;
  logic                axi_rvalid;
  logic                axi_rready;

  modport master (
    output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp,
    input  axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp,
    output axi_rvalid
  );

endinterface

// File: rtl/axi_lite_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arbiter2
  import axi_lite_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  output logic   if_gnt_o,
  output logic   dm_gnt_o,
  output owner_e owner_o
);

  owner_e last_q;

  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    owner_o  = OwnIf;
    if (en_i) begin
      if (if_req_i && (!dm_req_i || last_q == OwnDm)) begin
        if_gnt_o = 1'b1;
      end else if (dm_req_i) begin
        dm_gnt_o = 1'b1;
        owner_o  = OwnDm;
      end
    end
  end

  // Resetting to DM makes fetch win the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OwnDm;
    end else if (if_gnt_o) begin
      last_q <= OwnIf;
    end else if (dm_gnt_o) begin
      last_q <= OwnDm;
    end
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master port between fetch (read-only) and data (read/write) requesters,
// one transaction at a time.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [2:0]  IF_PROT = 3'b100,
  parameter logic [2:0]  DM_PROT = 3'b000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rsp_err,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_gnt,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_rsp_err,
  output logic                axi_error,
  axi_lite_arbiter_if.master  axi
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, arb_owner;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [2:0]          prot_q;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
  logic                if_err_q, dm_err_q;
  logic                axi_error_q;
  logic                any_gnt, aw_hs, w_hs, r_capture, b_capture;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     ((state_q == StIdle) && rst_n),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .if_gnt_o (if_gnt),
    .dm_gnt_o (dm_gnt),
    .owner_o  (arb_owner)
  );

  assign any_gnt = if_gnt | dm_gnt;

  // Every valid/ready is a decode of registered state, so no ready feeds a valid combinationally.
  assign axi.axi_arvalid = (state_q == StRdAr);
  assign axi.axi_rready  = (state_q == StRdR);
  assign axi.axi_awvalid = (state_q == StWrAww) && !aw_done_q;
  assign axi.axi_wvalid  = (state_q == StWrAww) && !w_done_q;
  assign axi.axi_bready  = (state_q == StWrB);
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_arprot  = prot_q;
  assign axi.axi_awprot  = prot_q;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = wstrb_q;

  assign aw_hs     = axi.axi_awvalid && axi.axi_awready;
  assign w_hs      = axi.axi_wvalid && axi.axi_wready;
  assign r_capture = (state_q == StRdR) && axi.axi_rvalid;
  assign b_capture = (state_q == StWrB) && axi.axi_bvalid;

  assign if_rsp_valid = (state_q == StRsp) && (owner_q == OwnIf);
  assign dm_rsp_valid = (state_q == StRsp) && (owner_q == OwnDm);
  assign if_rdata     = if_rdata_q;
  assign if_rsp_err   = if_err_q;
  assign dm_rdata     = dm_rdata_q;
  assign dm_rsp_err   = dm_err_q;
  assign axi_error    = axi_error_q;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      StIdle: begin
        if (any_gnt) begin
          state_d   = (dm_gnt && dm_we) ? StWrAww : StRdAr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StRdAr:  if (axi.axi_arready) state_d = StRdR;
      StRdR:   if (axi.axi_rvalid) state_d = StRsp;
      StWrAww: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = StWrB;
      end
      StWrB:   if (axi.axi_bvalid) state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnDm;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
      axi_error_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (any_gnt) begin
        owner_q <= arb_owner;
        addr_q  <= dm_gnt ? dm_addr : if_addr;
        wdata_q <= dm_gnt ? dm_wdata : '0;
        wstrb_q <= dm_gnt ? dm_wstrb : '0;
        prot_q  <= dm_gnt ? DM_PROT : IF_PROT;
      end
      // Requester outputs load at the edge that enters RSP and then hold until the next response.
      if (r_capture) begin
        if (owner_q == OwnIf) begin
          if_rdata_q <= axi.axi_rdata;
          if_err_q   <= (axi.axi_rresp != RespOkay);
        end else begin
          dm_rdata_q <= axi.axi_rdata;
          dm_err_q   <= (axi.axi_rresp != RespOkay);
        end
        if (axi.axi_rresp != RespOkay) axi_error_q <= 1'b1;
      end
      if (b_capture) begin
        dm_rdata_q <= '0;
        dm_err_q   <= (axi.axi_bresp != RespOkay);
        if (axi.axi_bresp != RespOkay) axi_error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios plus random traffic against a memory model,
// with a queue-based scoreboard checked by a separate monitor.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  typedef struct {
    logic [31:0] rd;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rsp_valid, if_rsp_err;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic        dm_gnt, dm_rsp_valid, dm_rsp_err, axi_error;
  logic [31:0] dm_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_PROT(3'b100), .DM_PROT(3'b000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rsp_valid (if_rsp_valid),
    .if_rdata     (if_rdata),
    .if_rsp_err   (if_rsp_err),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_wstrb     (dm_wstrb),
    .dm_gnt       (dm_gnt),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rdata     (dm_rdata),
    .dm_rsp_err   (dm_rsp_err),
    .axi_error    (axi_error),
    .axi          (bus)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    total++;
    bad++;
    $display("FAIL %s: event not observed within its bound", name);
  endfunction

  function automatic logic [31:0] init_word(int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 64) ? 32'hDEAD_BEEF : {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // ---------------- Slave: memory, error region at addr[15], per-channel ready delays.
  logic [31:0] smem [256];
  int  ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  bit  rnd_delay = 1'b0;
  int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, ar_lim, r_lim, aw_lim, w_lim, b_lim;
  bit  r_pend, aw_got, w_got, b_pend;
  logic [31:0] r_data, aw_a, w_d;
  logic [3:0]  w_s;
  logic [1:0]  r_resp, b_resp;

  function automatic int pick(int d);
    return rnd_delay ? int'($urandom_range(0, 3)) : d;
  endfunction

  assign bus.axi_arready = bus.axi_arvalid && (ar_cnt >= ar_lim);
  assign bus.axi_rvalid  = r_pend && (r_cnt >= r_lim);
  assign bus.axi_rdata   = r_data;
  assign bus.axi_rresp   = r_resp;
  assign bus.axi_awready = bus.axi_awvalid && !aw_got && (aw_cnt >= aw_lim);
  assign bus.axi_wready  = bus.axi_wvalid && !w_got && (w_cnt >= w_lim);
  assign bus.axi_bvalid  = b_pend && (b_cnt >= b_lim);
  assign bus.axi_bresp   = b_resp;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
      {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} <= '0;
      {ar_lim, r_lim, aw_lim, w_lim, b_lim} <= '0;
      {r_pend, aw_got, w_got, b_pend} <= '0;
      {r_data, aw_a, w_d, w_s, r_resp, b_resp} <= '0;
    end else begin
      if (!bus.axi_arvalid || bus.axi_arready) begin
        ar_cnt <= 0;
        ar_lim <= pick(ar_delay);
      end else ar_cnt <= ar_cnt + 1;
      if (!bus.axi_awvalid || bus.axi_awready) begin
        aw_cnt <= 0;
        aw_lim <= pick(aw_delay);
      end else aw_cnt <= aw_cnt + 1;
      if (!bus.axi_wvalid || bus.axi_wready) begin
        w_cnt <= 0;
        w_lim <= pick(w_delay);
      end else w_cnt <= w_cnt + 1;
      if (bus.axi_arready) begin
        r_pend <= 1'b1;
        r_cnt  <= 0;
        r_lim  <= pick(r_delay);
        r_data <= smem[bus.axi_araddr[9:2]];
        r_resp <= bus.axi_araddr[15] ? 2'b10 : 2'b00;
      end else if (r_pend && !bus.axi_rvalid) r_cnt <= r_cnt + 1;
      if (bus.axi_rvalid && bus.axi_rready) r_pend <= 1'b0;
      if (bus.axi_awready) begin
        aw_got <= 1'b1;
        aw_a   <= bus.axi_awaddr;
      end
      if (bus.axi_wready) begin
        w_got <= 1'b1;
        w_d   <= bus.axi_wdata;
        w_s   <= bus.axi_wstrb;
      end
      if (aw_got && w_got && !b_pend) begin
        if (!aw_a[15])
          for (int i = 0; i < 4; i++)
            if (w_s[i]) smem[aw_a[9:2]][8*i +: 8] <= w_d[8*i +: 8];
        b_pend <= 1'b1;
        b_cnt  <= 0;
        b_lim  <= pick(b_delay);
        b_resp <= aw_a[15] ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (b_pend && !bus.axi_bvalid) b_cnt <= b_cnt + 1;
      if (bus.axi_bvalid && bus.axi_bready) b_pend <= 1'b0;
    end
  end

  // ---------------- Reference model: word memory updated in grant order.
  logic [31:0] mmem [256];
  exp_t if_q[$];
  exp_t dm_q[$];

  function automatic void reset_model();
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
  endfunction

  function automatic exp_t model(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    exp_t e;
    int idx;
    idx   = int'(a[9:2]);
    e.err = a[15];
    e.rd  = '0;
    if (!we) e.rd = mmem[idx];
    else if (!e.err)
      for (int i = 0; i < 4; i++) if (s[i]) mmem[idx][8*i +: 8] = d[8*i +: 8];
    return e;
  endfunction

  task automatic req_if(input logic [31:0] a, output int gcyc, output int waits);
    @(posedge clk); #1;
    if_req = 1'b1;
    if_addr = a;
    gcyc = -1;
    waits = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (if_gnt) begin
        gcyc = cyc;
        if_q.push_back(model(1'b0, a, '0, '0));
        break;
      end
      waits++;
    end
    if (gcyc < 0) fail("if_gnt_timeout");
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic req_dm(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int gcyc, output int waits);
    @(posedge clk); #1;
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    dm_wstrb = s;
    gcyc = -1;
    waits = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dm_gnt) begin
        gcyc = cyc;
        dm_q.push_back(model(we, a, d, s));
        break;
      end
      waits++;
    end
    if (gcyc < 0) fail("dm_gnt_timeout");
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (if_q.size() == 0 && dm_q.size() == 0 && !if_req && !dm_req) return;
    end
    fail("drain_timeout");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 7) == 0) ? 32'h0000_8000 : 32'h0;
    return base | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // ---------------- Monitor: scoreboard pops, arbitration order, channel payload and stability.
  bit          last_dm, cur_dm, err_seen, ar_p, aw_p, w_p;
  logic [31:0] cur_addr, cur_wd, ar_a, aw_pa, w_pd;
  logic [3:0]  cur_ws;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      if_q.delete();
      dm_q.delete();
      {last_dm, err_seen, ar_p, aw_p, w_p} = 5'b10000;
    end else begin
      if (if_gnt || dm_gnt) begin
        check("gnt_onehot", 32'(if_gnt & dm_gnt), 32'd0);
        if (if_req && dm_req) check("rr_winner", 32'(dm_gnt), 32'(!last_dm));
        else check("gnt_to_requester", 32'(if_gnt), 32'(if_req));
        last_dm  = dm_gnt;
        cur_dm   = dm_gnt;
        cur_addr = dm_gnt ? dm_addr : if_addr;
        cur_wd   = dm_wdata;
        cur_ws   = dm_wstrb;
      end
      if (if_rsp_valid) begin
        if (if_q.size() == 0) fail("if_rsp_expected");
        else begin
          e = if_q.pop_front();
          err_seen |= e.err;
          check("if_rdata", if_rdata, e.rd);
          check("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
          check("axi_error", 32'(axi_error), 32'(err_seen));
        end
      end
      if (dm_rsp_valid) begin
        if (dm_q.size() == 0) fail("dm_rsp_expected");
        else begin
          e = dm_q.pop_front();
          err_seen |= e.err;
          check("dm_rdata", dm_rdata, e.rd);
          check("dm_rsp_err", 32'(dm_rsp_err), 32'(e.err));
          check("axi_error", 32'(axi_error), 32'(err_seen));
        end
      end
      if (if_rsp_valid && dm_rsp_valid) fail("single_rsp");
      if (bus.axi_arvalid && bus.axi_arready) begin
        check("araddr", bus.axi_araddr, cur_addr);
        check("arprot", 32'(bus.axi_arprot), cur_dm ? 32'd0 : 32'd4);
      end
      if (bus.axi_awvalid && bus.axi_awready) begin
        check("awaddr", bus.axi_awaddr, cur_addr);
        check("awprot", 32'(bus.axi_awprot), 32'd0);
      end
      if (bus.axi_wvalid && bus.axi_wready) begin
        check("wdata", bus.axi_wdata, cur_wd);
        check("wstrb", 32'(bus.axi_wstrb), 32'(cur_ws));
      end
      if (ar_p) begin
        check("arvalid_hold", 32'(bus.axi_arvalid), 32'd1);
        check("araddr_stable", bus.axi_araddr, ar_a);
      end
      if (aw_p) begin
        check("awvalid_hold", 32'(bus.axi_awvalid), 32'd1);
        check("awaddr_stable", bus.axi_awaddr, aw_pa);
      end
      if (w_p) begin
        check("wvalid_hold", 32'(bus.axi_wvalid), 32'd1);
        check("wdata_stable", bus.axi_wdata, w_pd);
      end
      ar_p  = bus.axi_arvalid && !bus.axi_arready;
      aw_p  = bus.axi_awvalid && !bus.axi_awready;
      w_p   = bus.axi_wvalid && !bus.axi_wready;
      ar_a  = bus.axi_araddr;
      aw_pa = bus.axi_awaddr;
      w_pd  = bus.axi_wdata;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed scenarios, then random traffic.
  initial begin
    int g, gi, gd, w, lat, rsp_cnt;
    bit found;
    reset_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_arvalid", 32'(bus.axi_arvalid), 32'd0);
    check("rst_awvalid", 32'(bus.axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(bus.axi_wvalid), 32'd0);
    check("rst_rready", 32'(bus.axi_rready), 32'd0);
    check("rst_bready", 32'(bus.axi_bready), 32'd0);
    check("rst_rsp", 32'({if_rsp_valid, dm_rsp_valid, if_gnt, dm_gnt}), 32'd0);
    check("rst_araddr", bus.axi_araddr, 32'd0);
    check("rst_axi_error", 32'(axi_error), 32'd0);

    // Ties: fetch first, data in the IDLE right after the fetch response.
    for (int r = 0; r < 4; r++) begin
      int ti, td, wi, wd;
      fork
        req_if(32'h200 + 32'(r * 4), ti, wi);
        req_dm(1'b0, 32'h300 + 32'(r * 4), '0, '0, td, wd);
      join
      check("tie_fetch_first", 32'(ti < td), 32'd1);
      check("dm_gnt_after_rsp", 32'(td - ti), 32'd4);
    end
    drain();

    // Fetch only, zero-wait slave.
    req_if(32'h100, g, w);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("fetch_arvalid", 32'(bus.axi_arvalid), 32'd1);
        check("fetch_araddr", bus.axi_araddr, 32'h100);
        check("fetch_arprot", 32'(bus.axi_arprot), 32'd4);
      end
      if (if_rsp_valid && lat < 0) begin
        lat = k;
        check("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
      end
    end
    check("fetch_latency", 32'(lat), 32'd3);
    drain();

    // Skewed write: W accepted at once, AW three cycles later.
    aw_delay = 3;
    req_dm(1'b1, 32'h10, 32'h1234_5678, 4'b0011, g, w);
    rsp_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("skew_wvalid_up", 32'(bus.axi_wvalid), 32'd1);
      if (k >= 2 && k <= 5) check("skew_wvalid_down", 32'(bus.axi_wvalid), 32'd0);
      if (k <= 4) begin
        check("skew_awvalid_hold", 32'(bus.axi_awvalid), 32'd1);
        check("skew_bready_early", 32'(bus.axi_bready), 32'd0);
      end
      if (k == 5) check("skew_awvalid_down", 32'(bus.axi_awvalid), 32'd0);
      if (dm_rsp_valid) rsp_cnt++;
    end
    check("skew_rsp_once", 32'(rsp_cnt), 32'd1);
    aw_delay = 0;
    drain();

    // Error response on a data read, then OKAY traffic must leave axi_error set.
    req_dm(1'b0, 32'h8040, '0, '0, g, w);
    req_if(32'h14, g, w);
    req_dm(1'b0, 32'h10, '0, '0, g, w);
    drain();
    check("axi_error_sticky", 32'(axi_error), 32'd1);

    // AR backpressure with a second fetch waiting.
    ar_delay = 10;
    req_if(32'h104, g, w);
    if_req = 1'b1;
    if_addr = 32'h108;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("bp_arvalid", 32'(bus.axi_arvalid), 32'd1);
      check("bp_araddr", bus.axi_araddr, 32'h104);
      check("bp_no_gnt", 32'(if_gnt), 32'd0);
    end
    if_req = 1'b0;
    ar_delay = 0;
    drain();

    // Random traffic with random channel delays.
    rnd_delay = 1'b1;
    fork
      for (int n = 0; n < 30; n++) begin
        int g1, w1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        req_if(rand_addr(), g1, w1);
      end
      for (int n = 0; n < 30; n++) begin
        int g2, w2;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        req_dm(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(1, 15)), g2, w2);
      end
    join
    drain();
    rnd_delay = 1'b0;

    // Reset while the write waits in WR_B.
    b_delay = 6;
    req_dm(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, g, w);
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.axi_bready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail("wr_b_reached");
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valids", 32'({bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid}), 32'd0);
    check("mid_rst_readies", 32'({bus.axi_rready, bus.axi_bready}), 32'd0);
    check("mid_rst_rsp", 32'({if_rsp_valid, dm_rsp_valid}), 32'd0);
    check("mid_rst_axi_error", 32'(axi_error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_delay = 0;
    reset_model();
    req_if(32'h100, g, w);
    check("idle_after_reset", 32'(w), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
